// File: rtl/sp_commit_unit_pkg.sv
// Shared processor constants for SP handling: op encodings, reset SP,
// commit FSM states, virtual SP unit constants and the SP step helper.
package sp_commit_unit_pkg;

    localparam logic [1:0] SP_OP_INC = 2'b10;
    localparam logic [1:0] SP_OP_DEC = 2'b01;

    localparam logic [7:0] SP_RESET_VAL = 8'hFF;
    localparam logic [1:0] R3_IDX       = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_RESYNC = 2'd2;

    localparam logic [7:0] VSP_STACK_TOP = 8'hFF;
    localparam logic [1:0] VSP_MAX_BEATS = 2'd3;

    typedef struct packed {
        logic [7:0] val;
        logic       wrap;
    } sp_next_t;

    // Increment has priority over decrement; zero beats means one step.
    // The ninth bit of the 9-bit sum/difference is the carry/borrow.
    function automatic sp_next_t sp_step(
        input logic [7:0] base,
        input logic [1:0] op,
        input logic [1:0] beats
    );
        sp_next_t   r;
        logic [8:0] w_sum;
        logic [7:0] w_mag;
        w_mag = (beats == 2'd0) ? 8'd1 : {6'd0, beats};
        w_sum = {1'b0, base};
        if ((op & SP_OP_INC) != 2'b00)
            w_sum = {1'b0, base} + {1'b0, w_mag};
        else if ((op & SP_OP_DEC) != 2'b00)
            w_sum = {1'b0, base} - {1'b0, w_mag};
        r.val  = w_sum[7:0];
        r.wrap = w_sum[8];
        return r;
    endfunction

endpackage

// File: rtl/sp_commit_unit_fifo.sv
// Pending SP commit queue (module sp_commit_fifo): DEPTH x WIDTH FIFO.
// Ports: clk, rst (async low), clr, push/din, pop/dout (head), count.
module sp_commit_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) r_wp <= nxt(r_wp);
            if (pop)  r_rp <= nxt(r_rp);
            r_cnt <= r_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) r_mem[r_wp] <= din;
    end

    assign dout  = r_mem[r_rp];
    assign count = r_cnt;

endmodule

// File: rtl/sp_commit_unit.sv
// SP commit unit: writes WB-stage SP updates to R3 via a dedicated port,
// queueing them while general writeback owns the RF. Ports: stall, flush,
// sp_*_Wb request, we_Wb/target_Wb/wb_data writeback; rf_sp_we/rf_sp_data,
// arch_SP, resync pulse, busy (queue full), sticky sp_err.
module sp_commit_unit
    import sp_commit_unit_pkg::*;
#(
    parameter logic [7:0] SP_RESET = SP_RESET_VAL,
    parameter int         QDEPTH   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       flush,
    input  logic       sp_valid_Wb,
    input  logic [1:0] sp_op_Wb,
    input  logic [1:0] sp_beats_Wb,
    input  logic [7:0] sp_base_Wb,
    input  logic       we_Wb,
    input  logic [1:0] target_Wb,
    input  logic [7:0] wb_data,
    output logic       rf_sp_we,
    output logic [7:0] rf_sp_data,
    output logic [7:0] arch_SP,
    output logic       resync,
    output logic       busy,
    output logic       sp_err
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [1:0]    r_state;
    logic          r_pend;
    logic          r_rf_we;
    logic [7:0]    r_rf_data;
    logic [7:0]    r_arch;
    logic          r_resync;
    logic          r_err;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_cnt_nx;
    logic [7:0]    w_head;
    sp_next_t      w_nx;
    logic          w_explicit;
    logic          w_busy;
    logic          w_empty;
    logic          w_take;
    logic          w_drop;
    logic          w_direct;
    logic          w_push;
    logic          w_pop;
    logic          w_empty_nx;
    logic          w_flush_any;
    logic [1:0]    w_state_nx;

    assign w_nx       = sp_step(sp_base_Wb, sp_op_Wb, sp_beats_Wb);
    assign w_explicit = we_Wb && (target_Wb == R3_IDX);
    assign w_busy     = (w_count == CW'(QDEPTH));
    assign w_empty    = (w_count == '0);
    assign w_take     = sp_valid_Wb && !stall && !w_busy && !w_explicit;
    assign w_drop     = sp_valid_Wb && !stall && w_busy;
    // Fast path only when nothing is queued ahead and the port is free.
    assign w_direct   = w_take && w_empty && !we_Wb;
    assign w_push     = w_take && !w_direct;
    assign w_pop      = !w_empty && !we_Wb;
    assign w_cnt_nx   = w_count + CW'(w_push) - CW'(w_pop);
    assign w_empty_nx = (w_cnt_nx == '0);
    // Flushes seen while entries were queued are held until they drain.
    assign w_flush_any = flush || r_pend;

    sp_commit_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_explicit),
        .push  (w_push),
        .din   (w_nx.val),
        .pop   (w_pop),
        .dout  (w_head),
        .count (w_count)
    );

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_explicit)       w_state_nx = ST_RESYNC;
                else if (!w_empty_nx) w_state_nx = ST_DRAIN;
                else if (w_flush_any) w_state_nx = ST_RESYNC;
            end
            ST_DRAIN: begin
                if (w_explicit)      w_state_nx = ST_RESYNC;
                else if (w_empty_nx) w_state_nx = w_flush_any ? ST_RESYNC
                                                               : ST_IDLE;
            end
            ST_RESYNC: w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_pend    <= 1'b0;
            r_rf_we   <= 1'b0;
            r_rf_data <= 8'h00;
            r_arch    <= SP_RESET;
            r_resync  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_pend   <= (w_state_nx == ST_RESYNC) ? 1'b0
                      : (r_pend || flush || w_explicit);
            // The pulse trails the RESYNC state so arch_SP is settled first.
            r_resync <= (r_state == ST_RESYNC);
            r_err    <= r_err || (w_take && w_nx.wrap) || w_drop;
            r_rf_we  <= w_pop || w_direct;
            if (w_explicit) begin
                r_arch <= wb_data;
            end else if (w_pop) begin
                r_rf_data <= w_head;
                r_arch    <= w_head;
            end else if (w_direct) begin
                r_rf_data <= w_nx.val;
                r_arch    <= w_nx.val;
            end
        end
    end

    assign rf_sp_we   = r_rf_we;
    assign rf_sp_data = r_rf_data;
    assign arch_SP    = r_arch;
    assign resync     = r_resync;
    assign busy       = w_busy;
    assign sp_err     = r_err;

endmodule

// File: tb/tb_sp_commit_unit.sv
// Scoreboard bench for sp_commit_unit: a queue-based reference model
// predicts RF writes and resync pulses; a monitor checks them.
module tb_sp_commit_unit;

    localparam int QD = 2;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       sp_valid_Wb = 1'b0;
    logic [1:0] sp_op_Wb = 2'b00;
    logic [1:0] sp_beats_Wb = 2'b00;
    logic [7:0] sp_base_Wb = 8'h00;
    logic       we_Wb = 1'b0;
    logic [1:0] target_Wb = 2'b00;
    logic [7:0] wb_data = 8'h00;
    logic       rf_sp_we;
    logic [7:0] rf_sp_data;
    logic [7:0] arch_SP;
    logic       resync;
    logic       busy;
    logic       sp_err;

    sp_commit_unit #(
        .SP_RESET (8'hFF),
        .QDEPTH   (QD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .sp_valid_Wb (sp_valid_Wb),
        .sp_op_Wb    (sp_op_Wb),
        .sp_beats_Wb (sp_beats_Wb),
        .sp_base_Wb  (sp_base_Wb),
        .we_Wb       (we_Wb),
        .target_Wb   (target_Wb),
        .wb_data     (wb_data),
        .rf_sp_we    (rf_sp_we),
        .rf_sp_data  (rf_sp_data),
        .arch_SP     (arch_SP),
        .resync      (resync),
        .busy        (busy),
        .sp_err      (sp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int v;
    } ev_t;

    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;
    int   mq[$];
    ev_t  exp_wr[$];
    int   exp_rs[$];
    int   m_arch = 255;
    bit   m_err = 1'b0;
    bit   m_pend = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference: a FIFO of committed SP values; a request in cycle t
    // shows up as an RF write in t+1, resync two cycles after its cause.
    function automatic void model(input bit v, input logic [1:0] op,
                                  input int bt, input int base,
                                  input bit we, input int tg,
                                  input int wd, input bit st,
                                  input bit fl);
        int t = cyc;
        int sz = mq.size();
        int n;
        int steps;
        ev_t e;
        if (we && tg == 3) begin
            mq.delete();
            m_arch = wd;
            exp_rs.push_back(t + 2);
            m_pend = 1'b0;
            return;
        end
        if (sz > 0 && !we) begin
            n = mq.pop_front();
            e.c = t + 1;
            e.v = n;
            exp_wr.push_back(e);
            m_arch = n;
        end
        if (v && !st) begin
            if (sz == QD) begin
                m_err = 1'b1;
            end else begin
                steps = (bt == 0) ? 1 : bt;
                n = op[1] ? base + steps : base - steps;
                if (n < 0 || n > 255) m_err = 1'b1;
                n = (n + 256) % 256;
                if (sz == 0 && !we) begin
                    e.c = t + 1;
                    e.v = n;
                    exp_wr.push_back(e);
                    m_arch = n;
                end else begin
                    mq.push_back(n);
                end
            end
        end
        if (fl) m_pend = 1'b1;
        if (m_pend && mq.size() == 0) begin
            exp_rs.push_back(t + 2);
            m_pend = 1'b0;
        end
    endfunction

    task automatic step(input bit v, input logic [1:0] op,
                        input logic [1:0] bt, input logic [7:0] base,
                        input bit we, input logic [1:0] tg,
                        input logic [7:0] wd, input bit st,
                        input bit fl);
        sp_valid_Wb = v;
        sp_op_Wb    = op;
        sp_beats_Wb = bt;
        sp_base_Wb  = base;
        we_Wb       = we;
        target_Wb   = tg;
        wb_data     = wd;
        stall       = st;
        flush       = fl;
        model(v, op, int'(bt), int'(base), we, int'(tg), int'(wd), st, fl);
        @(negedge clk);
        chk("busy", int'(busy), int'(mq.size() == QD));
        chk("err", int'(sp_err), int'(m_err));
        chk("arch", int'(arch_SP), m_arch);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 2'b00, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  rc;
        if (mon_on && rst) begin
            if (rf_sp_we) begin
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexp cyc=%0d got=%0h want=none",
                             cyc, rf_sp_data);
                end else begin
                    e = exp_wr.pop_front();
                    if (e.c != cyc || rf_sp_data != 8'(e.v) ||
                        arch_SP != 8'(e.v)) begin
                        bad++;
                        $display("FAIL wr cyc=%0d got=%0h/%0h want=%0h@%0d",
                                 cyc, rf_sp_data, arch_SP, e.v, e.c);
                    end
                end
            end else if (exp_wr.size() != 0 && exp_wr[0].c <= cyc) begin
                e = exp_wr.pop_front();
                total++;
                bad++;
                $display("FAIL wr_miss cyc=%0d got=none want=%0h@%0d",
                         cyc, e.v, e.c);
            end
            if (resync) begin
                total++;
                if (exp_rs.size() == 0) begin
                    bad++;
                    $display("FAIL rs_unexp cyc=%0d got=1 want=0", cyc);
                end else begin
                    rc = exp_rs.pop_front();
                    if (rc != cyc) begin
                        bad++;
                        $display("FAIL rs cyc=%0d got=%0d want=%0d",
                                 cyc, cyc, rc);
                    end
                end
            end else if (exp_rs.size() != 0 && exp_rs[0] <= cyc) begin
                rc = exp_rs.pop_front();
                total++;
                bad++;
                $display("FAIL rs_miss cyc=%0d got=0 want=%0d", cyc, rc);
            end
        end
    end

    initial begin
        @(negedge clk);
        chk("rst_arch", int'(arch_SP), 8'hFF);
        chk("rst_we", int'(rf_sp_we), 0);
        chk("rst_data", int'(rf_sp_data), 0);
        chk("rst_rs", int'(resync), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(sp_err), 0);
        rst = 1'b1;
        mon_on = 1'b1;

        // direct write: 0x10 - 1
        step(1'b1, OP_DEC, 2'd1, 8'h10, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        idle(2);

        // two conflicting requests fill the queue, then drain in order
        step(1'b1, OP_DEC, 2'd1, 8'h20, 1'b1, 2'd0, 8'h55, 1'b0, 1'b0);
        step(1'b1, OP_DEC, 2'd1, 8'h1F, 1'b1, 2'd1, 8'h66, 1'b0, 1'b0);
        chk("busy_full", int'(busy), 1);
        idle(3);

        // underflow wrap: 0x00 - 2
        step(1'b1, OP_DEC, 2'd2, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        chk("wrap_err", int'(sp_err), 1);
        idle(3);
        chk("err_sticky", int'(sp_err), 1);

        // flush behind a queued entry
        step(1'b1, OP_DEC, 2'd1, 8'h40, 1'b1, 2'd2, 8'h11, 1'b0, 1'b0);
        step(1'b0, 2'b00, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        idle(4);

        // flush while idle
        step(1'b0, 2'b00, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        idle(4);

        // explicit R3 write beats a coincident INC request
        step(1'b1, OP_INC, 2'd1, 8'h50, 1'b1, 2'd3, 8'h80, 1'b0, 1'b0);
        chk("expl_arch", int'(arch_SP), 8'h80);
        chk("expl_we", int'(rf_sp_we), 0);
        idle(4);

        // reset with two entries queued
        step(1'b1, OP_DEC, 2'd1, 8'h30, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0);
        step(1'b1, OP_DEC, 2'd1, 8'h2F, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_arch", int'(arch_SP), 8'hFF);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_err", int'(sp_err), 0);
        mq.delete();
        exp_wr.delete();
        exp_rs.delete();
        m_arch = 255;
        m_err = 1'b0;
        m_pend = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        // randomized traffic: conflicts, stalls, drops, wraps
        for (int i = 0; i < 400; i++) begin
            logic       rv;
            logic       rwe;
            logic       rst_l;
            logic [1:0] rop;
            logic [1:0] rtg;
            rv    = ($urandom % 2) == 0;
            rop   = (($urandom % 2) == 0) ? OP_INC : OP_DEC;
            rwe   = ($urandom % 3) == 0;
            rtg   = 2'($urandom % 3);
            rst_l = ($urandom % 5) == 0;
            step(rv, rop, 2'($urandom % 4), 8'($urandom % 256),
                 rwe, rtg, 8'($urandom % 256), rst_l, 1'b0);
        end
        idle(6);
        chk("wr_left", exp_wr.size(), 0);
        chk("rs_left", exp_rs.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sp_commit_unit.md
SP_COMMIT_UNIT -- requirements
Module: sp_commit_unit

Interface
REQ-001 SHALL have parameter SP_RESET, default 8'hFF, reset value of architectural SP (matches R3 reset).
REQ-002 SHALL have parameter QDEPTH, default 2, number of pending SP commits held while the RF write port is busy.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hazard-unit stall; while high, no new request is accepted.
REQ-006 flush  input  1  pipeline flush of younger instructions.
REQ-007 sp_valid_Wb  input  1  WB-stage instruction modifies SP (push/pop/call/ret/intr).
REQ-008 sp_op_Wb  input  2  bit1 = increment (pop), bit0 = decrement (push); bit1 wins if both are set.
REQ-009 sp_beats_Wb  input  2  step magnitude 1..3; 0 treated as 1.
REQ-010 sp_base_Wb  input  8  SP value the instruction used (bypassed SP at issue).
REQ-011 we_Wb, target_Wb[1:0], wb_data[7:0]  input  1/2/8  general register writeback.
REQ-012 rf_sp_we  output  1  write strobe to R3 on the dedicated SP write port.
REQ-013 rf_sp_data  output  8  value written to R3.
REQ-014 arch_SP  output  8  committed architectural SP.
REQ-015 resync  output  1  one-cycle pulse telling the virtual SP unit to reload from arch_SP.
REQ-016 busy  output  1  high when the queue holds QDEPTH entries; the hazard unit stalls on it.
REQ-017 sp_err  output  1  sticky wrap error (stack overflow or underflow).

Function
REQ-018 A request is accepted when sp_valid_Wb=1, stall=0 and busy=0.
REQ-019 The new value is sp_base_Wb minus steps (decrement) or plus steps (increment), computed modulo 256.
REQ-020 An accepted request SHALL set sp_err on wrap: a decrement crossing below 8'h00, or an increment crossing above 8'hFF.
REQ-021 The SP port conflicts with general writeback when we_Wb=1 in the same cycle; general writeback has priority, and the SP value is enqueued.
REQ-022 With no conflict and an empty queue, the unit SHALL assert rf_sp_we with rf_sp_data = new value one cycle after acceptance (cycle N+1), and arch_SP SHALL update in the same cycle.
REQ-023 With a non-empty queue, a new request SHALL be appended; ordering is strictly FIFO.
REQ-024 The queue SHALL drain one entry per cycle in which we_Wb=0.
REQ-025 If we_Wb=1 with target_Wb=2'b11 (explicit R3 write), the unit SHALL clear the queue, set arch_SP = wb_data at N+1 with rf_sp_we=0 (the general port writes), and pulse resync at N+2.
REQ-026 If an explicit R3 write and an SP request occur in the same cycle, the explicit write wins and the SP request is discarded.
REQ-027 A request arriving while busy=1 and stall=0 SHALL be dropped and SHALL set sp_err.
REQ-028 The FSM SHALL have states IDLE (queue empty), DRAIN (queue non-empty) and RESYNC (one cycle, resync=1).
REQ-029 IDLE SHALL go to DRAIN on a conflicting accept.
REQ-030 DRAIN SHALL go to IDLE when the last entry is written and no flush is pending.
REQ-031 DRAIN SHALL go to RESYNC when the last entry is written and a flush is pending.
REQ-032 IDLE SHALL go to RESYNC on flush or on an explicit R3 write.
REQ-033 RESYNC SHALL always go to IDLE.
REQ-034 Flush SHALL NOT discard queued entries, because they are already committed; the flush is latched as pending and resync fires only after the queue empties.
REQ-035 A stall SHALL NOT block draining.

Reset
REQ-036 On rst=0 the unit SHALL set arch_SP=SP_RESET, clear the queue, state=IDLE, rf_sp_we=0, rf_sp_data=0, resync=0, busy=0, sp_err=0 and clear the flush-pending flag.
REQ-037 Reset asserted mid-drain SHALL discard queued entries; no rf_sp_we pulse SHALL occur after the rst edge.

Structure
REQ-038 The SP op encodings (INC/DEC), SP_RESET and the FSM state encoding SHALL live in the shared processor package, alongside the constants used by the virtual SP unit.
REQ-039 The pending queue SHALL be a sub-module sp_commit_fifo (depth QDEPTH, width 8, with count output).

Verification
REQ-040 The bench SHALL cover: base 8'h10, op DEC, beats 1, we_Wb=0 -> cycle N+1: rf_sp_we=1, rf_sp_data=8'h0F, arch_SP=8'h0F.
REQ-041 The bench SHALL cover: two DEC requests (base 8'h20 then 8'h1F) with we_Wb=1 on both -> busy=1 after the second; with we_Wb=0 thereafter, writes 8'h1F then 8'h1E on consecutive cycles.
REQ-042 The bench SHALL cover: base 8'h00, op DEC, beats 2 -> rf_sp_data=8'hFE, sp_err=1 and it stays 1.
REQ-043 The bench SHALL cover: flush while one entry is queued behind we_Wb=1 -> the entry is written first, and resync pulses exactly one cycle later.
REQ-044 The bench SHALL cover: explicit R3 write of 8'h80 coincident with an INC request -> arch_SP=8'h80, queue empty, resync at N+2, and no 8'h?+1 write.
REQ-045 The bench SHALL cover: rst asserted while 2 entries are queued -> arch_SP=8'hFF immediately, and no rf_sp_we afterwards.
